// File: rtl/uart_comm_if.sv
// uart_comm_if -- command/response handshake between uart_comm and the
// command dispatcher that consumes its commands.
//
// Signals:
//   cmd         [23:0] last complete command (opcode in [23:16])
//   cmd_rdy            sticky "new command" flag
//   clr_cmd_rdy        one-cycle pulse from the consumer, clears cmd_rdy
//   resp        [7:0]  response byte, sampled on send_resp
//   send_resp          one-cycle pulse, starts transmission of resp
//   resp_sent          sticky "response fully left TX" flag
//
// Modports:
//   slave  -- the UART endpoint (drives cmd, cmd_rdy, resp_sent)
//   master -- the consumer     (drives clr_cmd_rdy, resp, send_resp)
interface uart_comm_if;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  modport slave (
    output cmd, cmd_rdy, resp_sent,
    input  clr_cmd_rdy, resp, send_resp
  );

  modport master (
    input  cmd, cmd_rdy, resp_sent,
    output clr_cmd_rdy, resp, send_resp
  );
endinterface

// File: rtl/uart_comm.sv
// uart_comm -- device-side endpoint of the host UART link.
// Receives three 8N1 bytes on RX and assembles them into a 24-bit command
// (first byte = opcode in cmd[23:16]); sends 8-bit responses on TX.
// Receiver and transmitter run independently (full duplex).
//
// Parameters:
//   BAUD_DIV     clk cycles per bit (8..65535)
//   TIMEOUT_CYC  max idle gap between bytes of one command; only used when
//                the macro UART_COMM_TIMEOUT_EN is defined
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   RX     serial input from host (asynchronous, idles high)
//   TX     serial output to host (idles high)
//   host   uart_comm_if.slave: cmd, cmd_rdy, clr_cmd_rdy, resp, send_resp,
//          resp_sent
//
// Optional feature: define UART_COMM_TIMEOUT_EN to discard a partial command
// when the line stays idle for TIMEOUT_CYC cycles between its bytes.
module uart_comm #(
  parameter int BAUD_DIV    = 2604,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         RX,
  output logic         TX,
  uart_comm_if.slave   host
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic       {TX_IDLE, TX_XMIT} tx_state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

  // ---------------------------------------------------------------------
  // RX synchronizer and falling-edge detect
  // ---------------------------------------------------------------------
  logic rx_s1, rx_s2, rx_s3;
  logic rx_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall = rx_s3 & ~rx_s2;

  // ---------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------
  rx_state_t   rx_state, rx_next;
  logic [15:0] rx_baud;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_tick;
  logic        byte_ok;
  logic        byte_bad;

  assign rx_tick = (rx_baud == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next  = rx_state;
    byte_ok  = 1'b0;
    byte_bad = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      // Line back high at mid start bit means it was only a glitch.
      RX_START: if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP: begin
        if (rx_tick) begin
          rx_next  = RX_IDLE;
          byte_ok  = rx_s2;
          byte_bad = ~rx_s2;
        end
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  // The IDLE state keeps the counter preloaded with the half-bit delay so
  // the start-bit sample lands mid-bit; every later sample is one full bit on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_baud  <= 16'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_baud <= HALF_LAST;
          rx_bit  <= 3'd0;
        end
        RX_START: rx_baud <= rx_tick ? BAUD_LAST : rx_baud - 16'd1;
        RX_DATA: begin
          if (rx_tick) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            rx_baud  <= BAUD_LAST;
          end else begin
            rx_baud  <= rx_baud - 16'd1;
          end
        end
        RX_STOP: rx_baud <= rx_tick ? HALF_LAST : rx_baud - 16'd1;
        default: rx_baud <= HALF_LAST;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Inter-byte timeout (optional)
  // ---------------------------------------------------------------------
  logic [1:0] byte_cnt;
  logic       timeout_hit;

`ifdef UART_COMM_TIMEOUT_EN
  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYC - 1);
  logic [19:0] idle_cnt;
  logic        idle_run;

  // Only counts while a command is partially assembled and the line is idle;
  // a detected start bit restarts the wait.
  assign idle_run    = (byte_cnt != 2'd0) && (rx_state == RX_IDLE) && !rx_fall;
  assign timeout_hit = idle_run && (idle_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      idle_cnt <= 20'd0;
    else if (!idle_run || timeout_hit) idle_cnt <= 20'd0;
    else                             idle_cnt <= idle_cnt + 20'd1;
  end
`else
  // No timeout: a partial command waits indefinitely. The parameter is kept
  // so both builds share one instantiation interface.
  logic [19:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 20'(TIMEOUT_CYC);
  assign timeout_hit        = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Command assembly
  // ---------------------------------------------------------------------
  logic [7:0]  hold1, hold2;
  logic [23:0] cmd_r;
  logic        cmd_rdy_r;
  logic        cmd_done;

  assign cmd_done = byte_ok && (byte_cnt == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 2'd0;
      hold1    <= 8'd0;
      hold2    <= 8'd0;
      cmd_r    <= 24'd0;
    end else if (byte_bad || timeout_hit) begin
      byte_cnt <= 2'd0;
    end else if (byte_ok) begin
      case (byte_cnt)
        2'd0: begin
          hold1    <= rx_shift;
          byte_cnt <= 2'd1;
        end
        2'd1: begin
          hold2    <= rx_shift;
          byte_cnt <= 2'd2;
        end
        default: begin
          cmd_r    <= {hold1, hold2, rx_shift};
          byte_cnt <= 2'd0;
        end
      endcase
    end
  end

  // A completion in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cmd_rdy_r <= 1'b0;
    else if (cmd_done)         cmd_rdy_r <= 1'b1;
    else if (host.clr_cmd_rdy) cmd_rdy_r <= 1'b0;
  end

  assign host.cmd     = cmd_r;
  assign host.cmd_rdy = cmd_rdy_r;

  // ---------------------------------------------------------------------
  // Transmitter FSM
  // ---------------------------------------------------------------------
  tx_state_t   tx_state, tx_next;
  logic [9:0]  tx_shift;
  logic [15:0] tx_baud;
  logic [3:0]  tx_bit;
  logic        tx_tick;
  logic        tx_load;
  logic        tx_done;
  logic        resp_sent_r;

  assign tx_tick = (tx_baud == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    tx_load = 1'b0;
    tx_done = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (host.send_resp) begin
          tx_load = 1'b1;
          tx_next = TX_XMIT;
        end
      end
      TX_XMIT: begin
        if (tx_tick && tx_bit == 4'd9) begin
          tx_done = 1'b1;
          tx_next = TX_IDLE;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  // The frame shifts out LSB first; ones shifted in keep TX high once the
  // stop bit has gone, so TX is simply the shift register's low bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift    <= '1;
      tx_baud     <= 16'd0;
      tx_bit      <= 4'd0;
      resp_sent_r <= 1'b0;
    end else if (tx_load) begin
      tx_shift    <= {1'b1, host.resp, 1'b0};
      tx_baud     <= BAUD_LAST;
      tx_bit      <= 4'd0;
      resp_sent_r <= 1'b0;
    end else if (tx_state == TX_XMIT) begin
      if (tx_tick) begin
        tx_shift <= {1'b1, tx_shift[9:1]};
        tx_baud  <= BAUD_LAST;
        tx_bit   <= tx_bit + 4'd1;
      end else begin
        tx_baud  <= tx_baud - 16'd1;
      end
      if (tx_done) resp_sent_r <= 1'b1;
    end
  end

  assign TX             = tx_shift[0];
  assign host.resp_sent = resp_sent_r;

endmodule

// File: tb/tb_uart_comm.sv
// tb_uart_comm -- self-checking bench for uart_comm (BAUD_DIV=16,
// TIMEOUT_CYC=2000). Host-side bytes are bit-banged on RX, TX frames are
// decoded mid-bit, and a queue-based command model predicts cmd/cmd_rdy.
module tb_uart_comm;
  localparam int BAUD = 16;
  localparam int TO   = 2000;

  logic clk = 1'b0;
  logic rst_n;
  logic RX;
  logic TX;

  uart_comm_if bus();

  uart_comm #(.BAUD_DIV(BAUD), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX    (RX),
    .TX    (TX),
    .host  (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state for the receive side.
  logic [7:0]  part[$];
  logic [23:0] m_cmd;
  logic        m_rdy;

  typedef struct packed {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [23:0] exp_cmd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Drive one 8N1 byte, all changes on falling clock edges. A bad stop bit
  // is followed by two idle bit times so the next start edge is visible.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BAUD) @(negedge clk);
    end
    RX = stop_bit;
    repeat (BAUD) @(negedge clk);
    RX = 1'b1;
    if (!stop_bit) repeat (2 * BAUD) @(negedge clk);
  endtask

  task automatic pulse_clr();
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
  endtask

  // Send a byte, advance the model, compare.
  task automatic rx_model_byte(input logic [7:0] b, input logic ok);
    send_byte(b, ok);
    if (ok) part.push_back(b);
    else    part.delete();
    if (part.size() == 3) begin
      m_cmd = {part[0], part[1], part[2]};
      m_rdy = 1'b1;
      part.delete();
    end
    check("rand_cmd", bus.cmd, m_cmd);
    check("rand_cmd_rdy", bus.cmd_rdy, m_rdy);
  endtask

  // Send one response frame and decode it. Called at a falling edge with
  // the transmitter idle (or finishing in this very cycle).
  task automatic tx_frame(input logic [7:0] r);
    logic [9:0] bits;
    int lat;
    bus.resp      = r;
    bus.send_resp = 1'b1;
    @(negedge clk);
    bus.send_resp = 1'b0;
    check("tx_start_low", TX, 1'b0);
    check("tx_resp_sent_clr", bus.resp_sent, 1'b0);
    bits = '0;
    lat  = -1;
    for (int m = 1; m <= 200; m++) begin
      @(negedge clk);
      if (m == 70) begin
        bus.resp      = ~r;
        bus.send_resp = 1'b1;
      end
      if (m == 71) bus.send_resp = 1'b0;
      if ((m % BAUD) == BAUD / 2 && m < 10 * BAUD) bits[m / BAUD] = TX;
      if (bus.resp_sent) begin
        lat = m;
        break;
      end
    end
    bus.send_resp = 1'b0;
    check("tx_start_bit", bits[0], 1'b0);
    check("tx_data", bits[8:1], r);
    check("tx_stop_bit", bits[9], 1'b1);
    check("tx_resp_sent_latency", lat, 10 * BAUD);
  endtask

  initial begin
    vec_t tbl [5];
    int   lows;
    logic [7:0] b;
    logic [23:0] exp_to;

    tbl[0] = '{8'h02, 8'h00, 8'h00, 24'h020000};
    tbl[1] = '{8'h03, 8'h00, 8'h2E, 24'h03002E};
    tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 24'hFFFFFF};
    tbl[3] = '{8'hA5, 8'h5A, 8'h3C, 24'hA55A3C};
    tbl[4] = '{8'h00, 8'h80, 8'h01, 24'h008001};

    rst_n           = 1'b0;
    RX              = 1'b1;
    bus.clr_cmd_rdy = 1'b0;
    bus.resp        = 8'h00;
    bus.send_resp   = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_tx", TX, 1'b1);
    check("rst_cmd", bus.cmd, 24'h0);
    check("rst_cmd_rdy", bus.cmd_rdy, 1'b0);
    check("rst_resp_sent", bus.resp_sent, 1'b0);

    // Table-driven commands, each cleared by the consumer
    for (int i = 0; i < 5; i++) begin
      send_byte(tbl[i].b0, 1'b1);
      check("tbl_rdy_partial", bus.cmd_rdy, 1'b0);
      send_byte(tbl[i].b1, 1'b1);
      send_byte(tbl[i].b2, 1'b1);
      check("tbl_cmd", bus.cmd, tbl[i].exp_cmd);
      check("tbl_cmd_rdy_set", bus.cmd_rdy, 1'b1);
      pulse_clr();
      check("tbl_cmd_rdy_clr", bus.cmd_rdy, 1'b0);
      pulse_clr();
      check("tbl_clr_when_low", bus.cmd_rdy, 1'b0);
      check("tbl_cmd_hold", bus.cmd, tbl[i].exp_cmd);
    end

    // Back-to-back commands, no idle time, no clear in between
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h2E, 1'b1);
    check("b2b_cmd1", bus.cmd, 24'h03002E);
    send_byte(8'h04, 1'b1);
    check("b2b_hold_byte4", bus.cmd, 24'h03002E);
    send_byte(8'h01, 1'b1);
    check("b2b_hold_byte5", bus.cmd, 24'h03002E);
    check("b2b_rdy_sticky", bus.cmd_rdy, 1'b1);
    send_byte(8'h00, 1'b1);
    check("b2b_cmd2", bus.cmd, 24'h040100);
    check("b2b_rdy", bus.cmd_rdy, 1'b1);
    pulse_clr();

    // Framing error on byte 2, then a start-bit glitch, then a good command
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    check("frm_rdy", bus.cmd_rdy, 1'b0);
    check("frm_cmd_hold", bus.cmd, 24'h040100);
    RX = 1'b0;
    repeat (3) @(negedge clk);
    RX = 1'b1;
    repeat (2 * BAUD) @(negedge clk);
    send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h03, 1'b1);
    check("frm_cmd", bus.cmd, 24'h050003);
    check("frm_cmd_rdy", bus.cmd_rdy, 1'b1);
    pulse_clr();

    // Randomized receive traffic against the command model
    m_cmd = 24'h050003;
    m_rdy = 1'b0;
    part.delete();
    for (int it = 0; it < 40; it++) begin
      b = 8'($urandom);
      rx_model_byte(b, ($urandom_range(0, 5) != 0));
      if ($urandom_range(0, 3) == 0) begin
        pulse_clr();
        m_rdy = 1'b0;
        check("rand_clr", bus.cmd_rdy, 1'b0);
      end
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    for (int k = 0; k < 3 && part.size() != 0; k++) rx_model_byte(8'($urandom), 1'b1);
    pulse_clr();

    // Response frames: the first carries a mid-frame send_resp that must be
    // ignored, the rest are chained in the cycle resp_sent rises.
    tx_frame(8'hA5);
    for (int f = 0; f < 4; f++) tx_frame(8'($urandom));
    lows = 0;
    for (int m = 0; m < 3 * BAUD; m++) begin
      @(negedge clk);
      if (!TX) lows++;
    end
    check("tx_no_extra_frame", lows, 0);
    check("tx_resp_sent_sticky", bus.resp_sent, 1'b1);

    // Inter-byte idle gap longer than TIMEOUT_CYC
    send_byte(8'h06, 1'b1);
    repeat (2500) @(negedge clk);
    send_byte(8'h08, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
`ifdef UART_COMM_TIMEOUT_EN
    exp_to = 24'h080000;
`else
    exp_to = 24'h060800;
`endif
    check("timeout_cmd", bus.cmd, exp_to);
    check("timeout_cmd_rdy", bus.cmd_rdy, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_comm.md
# uart_comm

Device-side command/response endpoint of the host UART link. It deserializes three 8N1 bytes from `RX` into one 24-bit command, flags it to the DSO command dispatcher, and serializes 8-bit responses back on `TX`. It sits between the board `RX`/`TX` pins and the command-processing FSM inside `DSO_dig`, and is the counterpart of `UART_comm_mstr`.

## Interface
- `BAUD_DIV`, default 2604: clk cycles per bit. Legal range 8..65535.
- `TIMEOUT_CYC`, default 1000000: maximum idle gap in clk cycles between bytes of one command. Used only when `UART_COMM_TIMEOUT_EN` is defined.

- `clk`  in  1  system clock; everything is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `RX`  in  1  serial data from the host. Asynchronous; idles high.
- `TX`  out  1  serial data to the host. Idles high.
- `cmd`  out  24  last complete command. Byte 1 is `cmd[23:16]` (opcode), byte 2 is `[15:8]`, byte 3 is `[7:0]`.
- `cmd_rdy`  out  1  a new `cmd` is valid. Sticky.
- `clr_cmd_rdy`  in  1  one-cycle pulse from the consumer; clears `cmd_rdy`.
- `resp`  in  8  response byte. Sampled on `send_resp`.
- `send_resp`  in  1  one-cycle pulse; starts transmission of `resp`.
- `resp_sent`  out  1  the last response has fully left `TX`. Sticky.

## Operation
- Reset values: `TX`=1, `cmd`=0, `cmd_rdy`=0, `resp_sent`=0. Receiver and transmitter both return to IDLE, and the byte counter returns to 0.
- Reset asserted mid-frame aborts the frame immediately. No partial byte survives.
- Receiver FSM states: IDLE, START, DATA, STOP.
  - `RX` passes through a two-flop synchronizer. A third flop provides falling-edge detection.
  - IDLE→START on a synchronized falling edge.
  - START samples at BAUD_DIV/2 (integer division). If the line is high at that sample, it is a glitch: return to IDLE. If low, go to DATA.
  - DATA takes 8 samples, each BAUD_DIV after the previous one, LSB first, shifted into an 8-bit shift register.
  - STOP takes one further sample BAUD_DIV later, then returns to IDLE.
  - Stop bit = 1: the byte is accepted.
  - Stop bit = 0 (framing error): the byte is discarded and the byte counter resets to 0.
- Command assembly:
  - A 2-bit byte counter (0..2) plus two 8-bit holding registers.
  - On the third accepted byte, `cmd` is loaded with {byte1, byte2, byte3}, `cmd_rdy` is set, and the counter returns to 0.
  - `cmd` changes only at third-byte completion. Bytes 1 and 2 of the next command do not disturb `cmd`.
  - If `cmd_rdy` is already set when a new command completes, `cmd` is overwritten and `cmd_rdy` stays 1.
  - If a completion and `clr_cmd_rdy` occur in the same cycle, set wins.
- Transmitter FSM states: IDLE, XMIT.
  - `send_resp` in IDLE loads a 10-bit frame {1, resp, 0}, clears `resp_sent`, and enters XMIT.
  - Each bit is held for BAUD_DIV cycles, LSB first after the start bit.
  - After the stop bit has been held its full BAUD_DIV, the FSM returns to IDLE and sets `resp_sent`.
  - `send_resp` during XMIT is ignored. The frame in progress is unaffected.
- Receiver and transmitter are fully independent (full duplex).

## Timing
- RX latency: `cmd_rdy` rises 1 cycle after the stop-bit sample of byte 3. The stop-bit sample falls 2 synchronizer cycles + BAUD_DIV/2 + 9·BAUD_DIV after the falling edge of byte 3's start bit, ±1 cycle.
- TX latency:
  - `TX` falls on the cycle after `send_resp` is sampled.
  - `resp_sent` rises exactly 10·BAUD_DIV cycles after `TX` falls.
  - A new `send_resp` is accepted in the same cycle `resp_sent` rises.
- The baud counter is 16 bits wide. It reloads at every bit boundary and is never free-running across frames.
- `cmd_rdy`:
  - Clears on the cycle after `clr_cmd_rdy`.
  - `clr_cmd_rdy` while `cmd_rdy`=0 has no effect.
- Back-to-back bytes with zero idle time between stop and start are received correctly.

## Configuration
- `UART_COMM_TIMEOUT_EN` defined:
  - A 20-bit idle counter runs whenever the byte counter is nonzero and the receiver is in IDLE.
  - The counter clears on every start-bit detection.
  - On reaching TIMEOUT_CYC, the byte counter resets to 0 and the partial command is discarded. `cmd` and `cmd_rdy` are untouched.
- Not defined: no timeout logic is present. A partial command waits indefinitely for its remaining bytes.

## Test plan
(All scenarios use BAUD_DIV=16 and TIMEOUT_CYC=2000.)
- Reset → `TX`=1, `cmd`=0, `cmd_rdy`=0, `resp_sent`=0.
- Host sends 0x02, 0x00, 0x00 (cfg gain, ggg=0, cc=0) → `cmd`=0x020000. `cmd_rdy` rises once and stays high until `clr_cmd_rdy`, then is 0 on the next cycle.
- Host sends 0x03,0x00,0x2E then 0x04,0x01,0x00 back-to-back with no `clr_cmd_rdy`:
  - `cmd` is 0x03002E after the first command.
  - `cmd` is 0x040100 after the second.
  - `cmd` is unchanged during bytes 4–5.
- `send_resp` with `resp`=0xA5 → `TX` frame decodes as 0xA5 at the bench. `resp_sent` rises 160 cycles after `TX` falls. A second `send_resp` mid-frame produces no second frame.
- Byte 2 is sent with stop bit forced 0, then 0x05,0x00,0x03 → the corrupted command is dropped and `cmd`=0x050003.
- With `UART_COMM_TIMEOUT_EN`: send 0x06, idle 2500 cycles, then 0x08,0x00,0x00 → `cmd`=0x080000. Without the macro, the same stimulus gives `cmd`=0x060800.
